// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bundle for nibble_serial_adder.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
// Optional: NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN adds the OVF result signal.
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C0;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             C4;
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
   logic             OVF;
`endif

   // Adder side: consumes operands, produces results.
   modport slave (
      input  in_valid,
      input  A,
      input  B,
      input  C0,
      input  out_ready,
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
      output OVF,
`endif
      output in_ready,
      output out_valid,
      output Sum,
      output C4
   );

   // Requester side: supplies operands, consumes results.
   modport master (
      output in_valid,
      output A,
      output B,
      output C0,
      output out_ready,
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
      input  OVF,
`endif
      input  in_ready,
      input  out_valid,
      input  Sum,
      input  C4
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add done one 4-bit slice per clock, LSB slice first.
// Latency: result valid WIDTH/4 cycles after the input handshake; II = WIDTH/4 + 2.
// Backpressure: in_ready only when idle; result held indefinitely while out_ready=0.
// Optional: NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN adds a registered two's-complement OVF flag.
module nibble_serial_adder #(
   parameter int WIDTH = 16   // multiple of 4, at least 4
) (
   input  logic                 clk,
   input  logic                 rst,
   nibble_serial_adder_if.slave bus
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   // The accumulator holds only the slices already finished; the current slice
   // comes straight from the nibble adder, so it is WIDTH-4 bits wide.
   localparam int AW      = (WIDTH > 4) ? WIDTH - 4 : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [AW-1:0]    r_acc;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_c4;
   logic [CW-1:0]    r_cnt;

   logic [4:0]       w_nib;
   logic [WIDTH-1:0] w_result;
   logic [AW-1:0]    w_acc_next;
   logic             w_last;

`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
   logic             r_sign_a;
   logic             r_sign_b;
   logic             r_ovf;
`endif

   // 4-bit ripple-carry slice: low nibbles of both shift registers plus the held carry.
   assign w_nib  = {1'b0, r_a_sh[3:0]} + {1'b0, r_b_sh[3:0]} + {4'd0, r_carry};
   assign w_last = (r_cnt == LAST_CNT);

   // Insert the new slice at the top of the result; on the last slice w_result is the full sum.
   generate
      if (WIDTH > 4) begin : g_wide
         assign w_result   = {w_nib[3:0], r_acc};
         assign w_acc_next = w_result[WIDTH-1:4];
      end else begin : g_narrow
         assign w_result   = w_nib[3:0];
         assign w_acc_next = '0;
      end
   endgenerate

   // Handshake flags decode registered state only, so no input reaches an output combinationally.
   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.Sum       = r_sum;
   assign bus.C4        = r_c4;
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
   assign bus.OVF       = r_ovf;
`endif

   // Sequencer: capture operands, add one slice per cycle, hold result until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_acc    <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_c4     <= 1'b0;
         r_cnt    <= '0;
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_ovf    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a_sh   <= bus.A;
                  r_b_sh   <= bus.B;
                  r_carry  <= bus.C0;
                  r_cnt    <= '0;
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
                  r_sign_a <= bus.A[WIDTH-1];
                  r_sign_b <= bus.B[WIDTH-1];
`endif
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_a_sh  <= r_a_sh >> 4;
               r_b_sh  <= r_b_sh >> 4;
               r_acc   <= w_acc_next;
               r_carry <= w_nib[4];
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  // Output registers only change here, so Sum/C4 stay put between results.
                  r_sum   <= w_result;
                  r_c4    <= w_nib[4];
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
                  r_ovf   <= (r_sign_a == r_sign_b) && (w_nib[3] != r_sign_a);
`endif
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: WIDTH=16 main instance plus a WIDTH=4 instance.
// Expected results come from a behavioural model pushed to a scoreboard at acceptance.
// OVF checks are compiled in when NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN is defined.
module tb_nibble_serial_adder;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         c4;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nibble_serial_adder_if #(.WIDTH(W)) bus ();
   nibble_serial_adder_if #(.WIDTH(4)) bus4 ();

   nibble_serial_adder #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   nibble_serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0);
      logic [W:0] t;
      exp_t       e;
      t     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c0};
      e.sum = t[W-1:0];
      e.c4  = t[W];
      e.ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for in_ready, performs one input handshake, records the model result.
   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0,
                          output int acc_cyc);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_wait in_ready=%b required 1", bus.in_ready);
      end
      bus.A        = a;
      bus.B        = b;
      bus.C0       = c0;
      bus.in_valid = 1'b1;
      tick();
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
      sb.push_back(model(a, b, c0));
   endtask

   // Bounded wait for out_valid; reports the number of cycles waited.
   task automatic wait_out(output int n);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.C0 = 1'b0; bus.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.C0 = 1'b0; bus4.out_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.Sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h want 0000", bus.Sum); end
      checks++; if (bus.C4 !== 1'b0) begin errors++; $display("FAIL reset_c4 got %b want 0", bus.C4); end
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
      checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.OVF); end
`endif
   endtask

   // Single operation: latency, in_ready low while busy, result, return to IDLE.
   task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c0);
      int   ka;
      int   n;
      int   busy_err;
      exp_t e;
      send_op(a, b, c0, ka);
      busy_err = 0;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         if (bus.in_ready !== 1'b0) busy_err++;
         tick();
         n++;
      end
      checks++; if (busy_err != 0) begin errors++; $display("FAIL %s_busy in_ready high %0d cycles, want 0", name, busy_err); end
      checks++; if (cyc - ka != 4) begin errors++; $display("FAIL %s_latency got %0d want 4", name, cyc - ka); end
      e = sb.pop_front();
      checks++; if (bus.Sum !== e.sum) begin errors++; $display("FAIL %s_sum got %h want %h", name, bus.Sum, e.sum); end
      checks++; if (bus.C4 !== e.c4) begin errors++; $display("FAIL %s_c4 got %b want %b", name, bus.C4, e.c4); end
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
      checks++; if (bus.OVF !== e.ovf) begin errors++; $display("FAIL %s_ovf got %b want %b", name, bus.OVF, e.ovf); end
`endif
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL %s_idle in_ready=%b out_valid=%b want 1/0", name, bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_basic();
      run_one("basic", 16'h1234, 16'h4321, 1'b1);
   endtask

   task automatic test_carry_ripple();
      run_one("ripple", 16'hFFFF, 16'h0001, 1'b0);
   endtask

`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
   task automatic test_signed_ovf();
      run_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
      run_one("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0);
   endtask
`endif

   task automatic test_backpressure();
      int   ka;
      int   n;
      exp_t e;
      send_op(16'h8421, 16'h1248, 1'b0, ka);
      wait_out(n);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout out_valid=%b want 1", bus.out_valid); end
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         bus.A        = W'($urandom);
         bus.B        = W'($urandom);
         bus.C0       = 1'($urandom);
         bus.in_valid = (i % 2 == 0);
         tick();
         checks++;
         if (bus.Sum !== e.sum || bus.C4 !== e.c4 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d sum=%h c4=%b ov=%b ir=%b want %h %b 1 0",
                     i, bus.Sum, bus.C4, bus.out_valid, bus.in_ready, e.sum, e.c4);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      int   ka;
      int   n;
      int   stray;
      exp_t e;
      send_op(16'hFFFF, 16'hFFFF, 1'b1, ka);
      void'(sb.pop_back());   // this operation is aborted, no result expected
      tick();                 // first RUN cycle
      rst = 1'b1;
      tick();                 // reset sampled on second RUN cycle
      rst = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_flags out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      checks++; if (bus.Sum !== 16'h0000 || bus.C4 !== 1'b0) begin
         errors++; $display("FAIL midrst_regs sum=%h c4=%b want 0000/0", bus.Sum, bus.C4);
      end
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.out_valid !== 1'b0) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL midrst_stray out_valid high %0d cycles want 0", stray); end
      send_op(16'h0001, 16'h0001, 1'b0, ka);
      wait_out(n);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_timeout out_valid=%b want 1", bus.out_valid); end
      e = sb.pop_front();
      checks++; if (bus.Sum !== e.sum || bus.C4 !== e.c4) begin
         errors++; $display("FAIL midrst_after sum=%h c4=%b want %h/%b", bus.Sum, bus.C4, e.sum, e.c4);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int   acc[2];
      int   n_acc;
      int   n_out;
      logic pre_rdy;
      exp_t e;
      n_acc = 0;
      n_out = 0;
      bus.out_ready = 1'b1;
      bus.A = 16'h0001; bus.B = 16'h0002; bus.C0 = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 40 && n_out < 2; i++) begin
         pre_rdy = bus.in_ready;
         tick();
         if (pre_rdy && bus.in_valid && n_acc < 2) begin
            acc[n_acc] = cyc;
            sb.push_back(model(bus.A, bus.B, bus.C0));
            n_acc++;
            if (n_acc == 1) begin
               bus.A = 16'h8000; bus.B = 16'h8000; bus.C0 = 1'b0;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL b2b_unexpected sum=%h with empty scoreboard", bus.Sum);
            end else begin
               e = sb.pop_front();
               if (bus.Sum !== e.sum || bus.C4 !== e.c4) begin
                  errors++; $display("FAIL b2b_result%0d sum=%h c4=%b want %h/%b", n_out, bus.Sum, bus.C4, e.sum, e.c4);
               end
            end
            n_out++;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checks++; if (n_out != 2 || n_acc != 2) begin errors++; $display("FAIL b2b_count acc=%0d out=%0d want 2/2", n_acc, n_out); end
      checks++; if (n_acc == 2 && acc[1] - acc[0] != 6) begin
         errors++; $display("FAIL b2b_interval got %0d want 6", acc[1] - acc[0]);
      end
   endtask

   task automatic test_width4();
      logic [3:0] va[2];
      logic [3:0] vb[2];
      logic [4:0] t;
      int         ka;
      int         n;
      va[0] = 4'h7; vb[0] = 4'h1;
      va[1] = 4'hF; vb[1] = 4'h1;
      for (int k = 0; k < 2; k++) begin
         t = {1'b0, va[k]} + {1'b0, vb[k]};
         bus4.A = va[k]; bus4.B = vb[k]; bus4.C0 = 1'b0;
         bus4.in_valid = 1'b1;
         tick();
         ka = cyc;
         bus4.in_valid = 1'b0;
         n = 0;
         while (!bus4.out_valid && n < 20) begin
            tick();
            n++;
         end
         checks++; if (cyc - ka != 1) begin errors++; $display("FAIL w4_latency%0d got %0d want 1", k, cyc - ka); end
         checks++; if (bus4.Sum !== t[3:0] || bus4.C4 !== t[4]) begin
            errors++; $display("FAIL w4_result%0d sum=%h c4=%b want %h/%b", k, bus4.Sum, bus4.C4, t[3:0], t[4]);
         end
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
         checks++; if (bus4.OVF !== ((va[k][3] == vb[k][3]) && (t[3] != va[k][3]))) begin
            errors++; $display("FAIL w4_ovf%0d got %b", k, bus4.OVF);
         end
`endif
         bus4.out_ready = 1'b1;
         tick();
         bus4.out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_ripple();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
`ifdef NIBBLE_SERIAL_ADDER_SIGNED_OVF_EN
      test_signed_ovf();
`endif
      test_width4();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
